nw_align_engine: RTL and testbench
==================================

NW_ALIGN_ENGINE -- requirements
Module: nw_align_engine

Interface
REQ-001 Parameters SHALL be: MAX_LEN, default 16, maximum characters per string; CWIDTH, default 2, bits per character; SWIDTH, default 16, signed score bits; CORD_LENGTH, default 8, bits per coordinate (2^CORD_LENGTH >= MAX_LEN).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  reset, synchronous, active-low.
- start  in  1  request an alignment; sampled only in IDLE.
- len1, len2  in  CORD_LENGTH  lengths of s1 and s2.
- s1, s2  in  MAX_LEN*CWIDTH  strings; character i is at bits [(MAX_LEN-1-i)*CWIDTH +: CWIDTH].
- w_match, w_mismatch, w_indel  in  SWIDTH  signed runtime weights.
- busy  out  1  engine is in FILL or TRACE.
- err  out  1  one-cycle pulse: start was rejected for an illegal length.
- score  out  SWIDTH  signed final score.
- score_valid  out  1  score is held valid.
- tb_valid  out  1  traceback beat is available.
- tb_ready  in  1  sink accepts the beat.
- tb_x, tb_y  out  CORD_LENGTH  cell coordinates (x indexes s2, y indexes s1).
- tb_dir  out  2  direction stored for the cell: 00 TOP, 01 LEFT, 10 CORNER.
- tb_last  out  1  beat is cell (0,0).

Function
REQ-003 The FSM SHALL have four states, IDLE, FILL, TRACE and DONE, with the transitions given in REQ-004 to REQ-010.
REQ-004 In IDLE, start=1 with 1<=len1<=MAX_LEN and 1<=len2<=MAX_LEN SHALL capture len1, len2, s1, s2 and the three weights, clear score_valid, and enter FILL on the next cycle.
REQ-005 In IDLE, start=1 with any length equal to 0 or greater than MAX_LEN SHALL pulse err for exactly one cycle and leave the FSM in IDLE.
REQ-006 start SHALL be ignored in every state other than IDLE, and captured operands SHALL NOT change until the next accepted start.
REQ-007 FILL SHALL compute exactly one cell per cycle in row-major order (y outer, x inner), so cell (y,x) is computed in FILL cycle y*len2+x.
- Per-cell scores: above_s = above + w_indel, left_s = left + w_indel, corner_s = corner + (s1[y]==s2[x] ? w_match : w_mismatch).
- Boundary inputs: row y=0 uses above = (x+1)*w_indel and corner = x*w_indel (except (0,0), REQ-008); column x=0 uses left = (y+1)*w_indel and corner = y*w_indel; cell (0,0) uses corner = 0.
REQ-008 Cell selection rule:
- above_s strictly greater than both others -> TOP.
- else left_s strictly greater than both others -> LEFT.
- otherwise -> CORNER; all ties, including above_s==left_s>corner_s, resolve to CORNER.
REQ-009 Storage and arithmetic:
- Each cell's 2-bit direction SHALL be stored in a MAX_LEN x MAX_LEN array.
- Scores SHALL need only one previous-row buffer plus one left register and one corner register.
- All arithmetic is signed SWIDTH two's complement and wraps without saturation.
REQ-010 After cell (len1-1,len2-1), the FSM SHALL enter TRACE. On that same edge, score is loaded with that cell's score and score_valid is set, i.e. len1*len2+1 cycles after the edge on which start is accepted.
REQ-011 TRACE SHALL begin at (len1-1,len2-1) with tb_valid=1 and present the current cell on tb_x, tb_y and tb_dir.
- A beat transfers only when tb_valid and tb_ready are both high.
- While tb_ready=0, all tb_* outputs SHALL hold stable.
REQ-012 On each transfer, the next cell SHALL be chosen in this priority order:
- x==0 or dir TOP -> y-1;
- else y==0 or dir LEFT -> x-1;
- else CORNER -> x-1 and y-1.
REQ-013 The beat for (0,0) SHALL carry tb_last=1. When it transfers, tb_valid drops and the FSM enters DONE.
REQ-014 DONE SHALL return to IDLE on the next cycle. score and score_valid SHALL hold until the next accepted start or until reset.
REQ-015 busy SHALL be 1 exactly in FILL and TRACE.

Reset
REQ-016 reset=0 at a rising edge SHALL, in any state including mid-FILL or mid-TRACE with a stalled beat, force IDLE and clear busy, err, score_valid, tb_valid and tb_last to 0, score to 0, tb_x, tb_y and tb_dir to 0, and all internal counters to 0.
REQ-017 The direction array SHALL need no reset, because it is fully rewritten before it is read.
REQ-018 The first start SHALL be accepted on the first edge with reset=1.

Verification
REQ-019 A bench SHALL cover these directed scenarios (CWIDTH=2, MAX_LEN=4, weights +1/-1/-1 unless stated):
- S1: len 4/4, s1=s2=0,1,2,3 -> score=4 after 17 cycles; beats (3,3),(2,2),(1,1),(0,0), all CORNER, last on (0,0).
- S2: len 2/2, s1=0,0, s2=1,1 -> all cells CORNER by tie rule; score=-2; beats (1,1),(0,0).
- S3: len1=1, len2=3, s1=2, s2=0,2,1 -> score=-1; 3 beats ending at (0,0) with tb_last=1.
- S4: S1 with tb_ready toggled 1-0-0-1 -> no beat lost or duplicated, and outputs stable while stalled.
- S5: start with len2=0, then len1=5 -> err pulses once per request, busy stays 0; a start asserted during FILL is ignored.
- S6: reset=0 mid-TRACE with tb_ready=0 -> all outputs are at their reset values next cycle; a following S1 run passes.

Source files
------------

// File: rtl/nw_align_engine.sv
// Needleman-Wunsch global alignment engine: fills the DP matrix one cell per
// cycle in row-major order, then streams the traceback path to (0,0).
module nw_align_engine #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned CWIDTH      = 2,
  parameter int unsigned SWIDTH      = 16,
  parameter int unsigned CORD_LENGTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CORD_LENGTH-1:0]    len1,
  input  logic [CORD_LENGTH-1:0]    len2,
  input  logic [MAX_LEN*CWIDTH-1:0] s1,
  input  logic [MAX_LEN*CWIDTH-1:0] s2,
  input  logic signed [SWIDTH-1:0]  w_match,
  input  logic signed [SWIDTH-1:0]  w_mismatch,
  input  logic signed [SWIDTH-1:0]  w_indel,
  output logic                      busy,
  output logic                      err,
  output logic signed [SWIDTH-1:0]  score,
  output logic                      score_valid,
  output logic                      tb_valid,
  input  logic                      tb_ready,
  output logic [CORD_LENGTH-1:0]    tb_x,
  output logic [CORD_LENGTH-1:0]    tb_y,
  output logic [1:0]                tb_dir,
  output logic                      tb_last
);

  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned SW = MAX_LEN * CWIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_TRACE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] DIR_TOP    = 2'b00;
  localparam logic [1:0] DIR_LEFT   = 2'b01;
  localparam logic [1:0] DIR_CORNER = 2'b10;

  logic [1:0]              state_q, state_d;
  logic [CORD_LENGTH-1:0]  len1_q, len1_d, len2_q, len2_d;
  logic [SW-1:0]           s1_q, s1_d, s2_q, s2_d;
  logic signed [SWIDTH-1:0] wm_q, wm_d, wmm_q, wmm_d, wi_q, wi_d;
  logic [CORD_LENGTH-1:0]  x_q, x_d, y_q, y_d;
  logic                    fill_done_q, fill_done_d;
  logic signed [SWIDTH-1:0] left_q, left_d, corner_q, corner_d, colb_q, colb_d;
  logic signed [SWIDTH-1:0] score_q, score_d;
  logic                    score_valid_q, score_valid_d;
  logic                    busy_q, busy_d, err_q, err_d;
  logic                    tb_valid_q, tb_valid_d, tb_last_q, tb_last_d;
  logic [CORD_LENGTH-1:0]  tb_x_q, tb_x_d, tb_y_q, tb_y_d;
  logic [1:0]              tb_dir_q, tb_dir_d;

  logic signed [SWIDTH-1:0] prev_row_q [MAX_LEN];
  logic [1:0]               dir_q [MAX_LEN][MAX_LEN];

  logic [CWIDTH-1:0]        ch1, ch2;
  logic signed [SWIDTH-1:0] above_in, left_in, corner_in;
  logic signed [SWIDTH-1:0] above_s, left_s, corner_s, cell_s;
  logic [1:0]               cell_dir;
  logic                     cell_we, len_ok;
  logic [CORD_LENGTH-1:0]   nx, ny, lx, ly;

  function automatic logic [CWIDTH-1:0] char_at(input logic [SW-1:0] s,
                                                input logic [IW-1:0] idx);
    logic [CWIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (IW'(i) == idx) c = s[(MAX_LEN-1-i)*CWIDTH +: CWIDTH];
    end
    return c;
  endfunction

  // Cell datapath; boundary values come from the running column-0 accumulator
  // and, on row 0, from the corner chain (x*w_indel -> (x+1)*w_indel).
  always_comb begin
    ch1       = char_at(s1_q, y_q[IW-1:0]);
    ch2       = char_at(s2_q, x_q[IW-1:0]);
    corner_in = (x_q == '0) ? colb_q : corner_q;
    above_in  = (y_q == '0) ? corner_in + wi_q : prev_row_q[x_q[IW-1:0]];
    left_in   = (x_q == '0) ? colb_q + wi_q : left_q;
    above_s   = above_in + wi_q;
    left_s    = left_in + wi_q;
    corner_s  = corner_in + ((ch1 == ch2) ? wm_q : wmm_q);
    if (above_s > left_s && above_s > corner_s) begin
      cell_dir = DIR_TOP;
      cell_s   = above_s;
    end else if (left_s > above_s && left_s > corner_s) begin
      cell_dir = DIR_LEFT;
      cell_s   = left_s;
    end else begin
      cell_dir = DIR_CORNER;
      cell_s   = corner_s;
    end
  end

  always_comb begin
    state_d       = state_q;
    len1_d        = len1_q;
    len2_d        = len2_q;
    s1_d          = s1_q;
    s2_d          = s2_q;
    wm_d          = wm_q;
    wmm_d         = wmm_q;
    wi_d          = wi_q;
    x_d           = x_q;
    y_d           = y_q;
    fill_done_d   = fill_done_q;
    left_d        = left_q;
    corner_d      = corner_q;
    colb_d        = colb_q;
    score_d       = score_q;
    score_valid_d = score_valid_q;
    err_d         = 1'b0;
    tb_valid_d    = tb_valid_q;
    tb_last_d     = tb_last_q;
    tb_x_d        = tb_x_q;
    tb_y_d        = tb_y_q;
    tb_dir_d      = tb_dir_q;
    cell_we       = 1'b0;
    nx            = tb_x_q;
    ny            = tb_y_q;
    lx            = len2_q - CORD_LENGTH'(1);
    ly            = len1_q - CORD_LENGTH'(1);
    len_ok        = (len1 != '0) && (len2 != '0) &&
                    ({1'b0, len1} <= (CORD_LENGTH+1)'(MAX_LEN)) &&
                    ({1'b0, len2} <= (CORD_LENGTH+1)'(MAX_LEN));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len1_d        = len1;
            len2_d        = len2;
            s1_d          = s1;
            s2_d          = s2;
            wm_d          = w_match;
            wmm_d         = w_mismatch;
            wi_d          = w_indel;
            x_d           = '0;
            y_d           = '0;
            colb_d        = '0;
            fill_done_d   = 1'b0;
            score_valid_d = 1'b0;
            state_d       = S_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (fill_done_q) begin
          // left_q holds the bottom-right cell; its direction is now in the array
          state_d       = S_TRACE;
          score_d       = left_q;
          score_valid_d = 1'b1;
          tb_valid_d    = 1'b1;
          tb_x_d        = lx;
          tb_y_d        = ly;
          tb_dir_d      = dir_q[ly[IW-1:0]][lx[IW-1:0]];
          tb_last_d     = (lx == '0) && (ly == '0);
        end else begin
          cell_we  = 1'b1;
          left_d   = cell_s;
          corner_d = above_in;
          if (x_q == lx) begin
            x_d    = '0;
            colb_d = colb_q + wi_q;
            if (y_q == ly) fill_done_d = 1'b1;
            else           y_d = y_q + CORD_LENGTH'(1);
          end else begin
            x_d = x_q + CORD_LENGTH'(1);
          end
        end
      end
      S_TRACE: begin
        if (tb_ready) begin
          if (tb_last_q) begin
            tb_valid_d = 1'b0;
            tb_last_d  = 1'b0;
            state_d    = S_DONE;
          end else begin
            if (tb_x_q == '0 || tb_dir_q == DIR_TOP) begin
              ny = tb_y_q - CORD_LENGTH'(1);
            end else if (tb_y_q == '0 || tb_dir_q == DIR_LEFT) begin
              nx = tb_x_q - CORD_LENGTH'(1);
            end else begin
              nx = tb_x_q - CORD_LENGTH'(1);
              ny = tb_y_q - CORD_LENGTH'(1);
            end
            tb_x_d    = nx;
            tb_y_d    = ny;
            tb_dir_d  = dir_q[ny[IW-1:0]][nx[IW-1:0]];
            tb_last_d = (nx == '0) && (ny == '0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FILL) || (state_d == S_TRACE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      len1_q        <= '0;
      len2_q        <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      wm_q          <= '0;
      wmm_q         <= '0;
      wi_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      fill_done_q   <= 1'b0;
      left_q        <= '0;
      corner_q      <= '0;
      colb_q        <= '0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      tb_valid_q    <= 1'b0;
      tb_last_q     <= 1'b0;
      tb_x_q        <= '0;
      tb_y_q        <= '0;
      tb_dir_q      <= '0;
    end else begin
      state_q       <= state_d;
      len1_q        <= len1_d;
      len2_q        <= len2_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      wm_q          <= wm_d;
      wmm_q         <= wmm_d;
      wi_q          <= wi_d;
      x_q           <= x_d;
      y_q           <= y_d;
      fill_done_q   <= fill_done_d;
      left_q        <= left_d;
      corner_q      <= corner_d;
      colb_q        <= colb_d;
      score_q       <= score_d;
      score_valid_q <= score_valid_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      tb_valid_q    <= tb_valid_d;
      tb_last_q     <= tb_last_d;
      tb_x_q        <= tb_x_d;
      tb_y_q        <= tb_y_d;
      tb_dir_q      <= tb_dir_d;
    end
  end

  // Row buffer and direction array are always written before being read.
  always_ff @(posedge clk) begin
    if (cell_we) begin
      dir_q[y_q[IW-1:0]][x_q[IW-1:0]] <= cell_dir;
      prev_row_q[x_q[IW-1:0]]         <= cell_s;
    end
  end

  assign busy        = busy_q;
  assign err         = err_q;
  assign score       = score_q;
  assign score_valid = score_valid_q;
  assign tb_valid    = tb_valid_q;
  assign tb_x        = tb_x_q;
  assign tb_y        = tb_y_q;
  assign tb_dir      = tb_dir_q;
  assign tb_last     = tb_last_q;

endmodule

// File: tb/tb_nw_align_engine.sv
// Directed bench for nw_align_engine; expected scores and traceback paths come
// from a full-matrix Needleman-Wunsch model plus hand-computed literals.
module tb_nw_align_engine;

  localparam int ML = 4;
  localparam int CW = 2;
  localparam int SW = 16;
  localparam int CL = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [CL-1:0]         len1, len2;
  logic [ML*CW-1:0]      s1, s2;
  logic signed [SW-1:0]  w_match, w_mismatch, w_indel;
  logic                  busy, err, score_valid, tb_valid, tb_ready, tb_last;
  logic signed [SW-1:0]  score;
  logic [CL-1:0]         tb_x, tb_y;
  logic [1:0]            tb_dir;

  always #5 clk = ~clk;

  nw_align_engine #(.MAX_LEN(ML), .CWIDTH(CW), .SWIDTH(SW), .CORD_LENGTH(CL)) dut (
    .clk(clk), .reset(reset), .start(start), .len1(len1), .len2(len2),
    .s1(s1), .s2(s2), .w_match(w_match), .w_mismatch(w_mismatch), .w_indel(w_indel),
    .busy(busy), .err(err), .score(score), .score_valid(score_valid),
    .tb_valid(tb_valid), .tb_ready(tb_ready), .tb_x(tb_x), .tb_y(tb_y),
    .tb_dir(tb_dir), .tb_last(tb_last)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic signed [SW-1:0] exp_score;
  int exp_x[$];
  int exp_y[$];
  int exp_d[$];
  int beat_idx = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full (len1+1)x(len2+1) score matrix, then walk the stored directions.
  task automatic model(input int l1, input int l2, input logic [7:0] a, input logic [7:0] b,
                       input logic signed [15:0] wm, input logic signed [15:0] wmm,
                       input logic signed [15:0] wi);
    logic signed [15:0] h [0:4][0:4];
    logic signed [15:0] up, lf, dg;
    int d [0:3][0:3];
    int y, x;
    h[0][0] = 0;
    for (int i = 1; i <= l2; i++) h[0][i] = h[0][i-1] + wi;
    for (int i = 1; i <= l1; i++) h[i][0] = h[i-1][0] + wi;
    for (int r = 0; r < l1; r++) begin
      for (int c = 0; c < l2; c++) begin
        up = h[r][c+1] + wi;
        lf = h[r+1][c] + wi;
        dg = h[r][c] + ((a[(3-r)*2 +: 2] == b[(3-c)*2 +: 2]) ? wm : wmm);
        if (up > lf && up > dg)      begin h[r+1][c+1] = up; d[r][c] = 0; end
        else if (lf > up && lf > dg) begin h[r+1][c+1] = lf; d[r][c] = 1; end
        else                         begin h[r+1][c+1] = dg; d[r][c] = 2; end
      end
    end
    exp_score = h[l1][l2];
    exp_x.delete(); exp_y.delete(); exp_d.delete();
    y = l1 - 1;
    x = l2 - 1;
    for (int n = 0; n < 16; n++) begin
      exp_x.push_back(x); exp_y.push_back(y); exp_d.push_back(d[y][x]);
      if (x == 0 && y == 0) break;
      if (x == 0 || d[y][x] == 0)      y--;
      else if (y == 0 || d[y][x] == 1) x--;
      else begin x--; y--; end
    end
  endtask

  // Checks every presented beat against the model path; a beat advances on ready.
  always @(negedge clk) begin
    if (cmp_en && tb_valid) begin
      if (beat_idx < exp_x.size()) begin
        chk("beat_x", tb_x, exp_x[beat_idx]);
        chk("beat_y", tb_y, exp_y[beat_idx]);
        chk("beat_dir", tb_dir, exp_d[beat_idx]);
        chk("beat_last", tb_last, (beat_idx == exp_x.size() - 1));
        if (tb_ready) beat_idx++;
      end else begin
        chk("beat_extra", beat_idx, exp_x.size() - 1);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_score_valid"}, score_valid, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_tb_valid"}, tb_valid, 0);
    chk({tag, "_tb_last"}, tb_last, 0);
    chk({tag, "_tb_x"}, tb_x, 0);
    chk({tag, "_tb_y"}, tb_y, 0);
    chk({tag, "_tb_dir"}, tb_dir, 0);
  endtask

  task automatic run_align(input string tag, input int l1, input int l2,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic signed [15:0] wm, input logic signed [15:0] wmm,
                           input logic signed [15:0] wi, input int stall_mode,
                           input bit poke_start, input bit use_lit,
                           input int lit_score, input int lit_beats);
    int cyc;
    int guard;
    model(l1, l2, a, b, wm, wmm, wi);
    if (use_lit) begin
      chk({tag, "_model_score"}, exp_score, lit_score);
      chk({tag, "_model_beats"}, exp_x.size(), lit_beats);
    end
    beat_idx = 0;
    cmp_en = 1'b1;
    len1 = CL'(l1); len2 = CL'(l2); s1 = a; s2 = b;
    w_match = wm; w_mismatch = wmm; w_indel = wi;
    tb_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_fill"}, busy, 1);
    chk({tag, "_err_accept"}, err, 0);
    chk({tag, "_sv_cleared"}, score_valid, 0);
    cyc = 0;
    while (!score_valid && cyc < 100) begin
      if (poke_start && cyc == 2) begin
        start = 1'b1; len1 = 1; len2 = 1; s1 = ~a; s2 = ~b; w_match = -16'sd5;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_fill_cycles"}, cyc, l1 * l2 + 1);
    chk({tag, "_score"}, score, exp_score);
    if (use_lit) chk({tag, "_score_lit"}, score, lit_score);
    guard = 0;
    while (busy && guard < 200) begin
      if (stall_mode == 1) tb_ready = (guard % 4 == 0) || (guard % 4 == 3);
      else                 tb_ready = 1'b1;
      step();
      guard++;
    end
    tb_ready = 1'b0;
    chk({tag, "_beats"}, beat_idx, exp_x.size());
    if (use_lit) chk({tag, "_beats_lit"}, beat_idx, lit_beats);
    chk({tag, "_tb_valid_drop"}, tb_valid, 0);
    chk({tag, "_busy_done"}, busy, 0);
    step();
    step();
    chk({tag, "_score_hold"}, score, exp_score);
    chk({tag, "_sv_hold"}, score_valid, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    cmp_en = 1'b0;
  endtask

  initial begin
    int cyc;
    reset = 1'b0; start = 1'b0; len1 = '0; len2 = '0; s1 = '0; s2 = '0;
    w_match = '0; w_mismatch = '0; w_indel = '0; tb_ready = 1'b0;
    step();
    step();
    check_reset_outputs("rst0");

    // Reset is released together with the first start request.
    reset = 1'b1;
    run_align("S1", 4, 4, 8'h1B, 8'h1B, 1, -1, -1, 0, 1'b0, 1'b1, 4, 4);
    run_align("S2", 2, 2, 8'h00, 8'h50, 1, -1, -1, 0, 1'b0, 1'b1, -2, 2);
    run_align("S3", 1, 3, 8'h80, 8'h24, 1, -1, -1, 0, 1'b0, 1'b1, -1, 3);
    run_align("S4", 4, 4, 8'h1B, 8'h1B, 1, -1, -1, 1, 1'b0, 1'b1, 4, 4);
    run_align("one", 1, 1, 8'hC0, 8'hC0, 1, -1, -1, 0, 1'b0, 1'b1, 1, 1);
    run_align("wts", 3, 4, 8'h4C, 8'h4C, 2, -3, -2, 1, 1'b0, 1'b0, 0, 0);
    run_align("mix", 4, 3, 8'hE4, 8'h9C, 3, -1, -2, 1, 1'b0, 1'b0, 0, 0);

    // S5: illegal lengths, then a start during FILL must be ignored.
    len1 = 4; len2 = 0; start = 1'b1;
    step();
    start = 1'b0;
    chk("S5_err_len2", err, 1);
    chk("S5_busy_len2", busy, 0);
    step();
    chk("S5_err_clear", err, 0);
    len1 = 5; len2 = 4; start = 1'b1;
    step();
    start = 1'b0;
    chk("S5_err_len1", err, 1);
    chk("S5_busy_len1", busy, 0);
    step();
    chk("S5_err_clear2", err, 0);
    chk("S5_busy_idle", busy, 0);
    run_align("S5fill", 4, 4, 8'h1B, 8'h1B, 1, -1, -1, 0, 1'b1, 1'b1, 4, 4);

    // S6: reset while a traceback beat is stalled.
    model(4, 4, 8'h1B, 8'h1B, 1, -1, -1);
    beat_idx = 0;
    cmp_en = 1'b1;
    len1 = 4; len2 = 4; s1 = 8'h1B; s2 = 8'h1B;
    w_match = 1; w_mismatch = -1; w_indel = -1; tb_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!score_valid && cyc < 100) begin
      step();
      cyc++;
    end
    chk("S6_fill_cycles", cyc, 17);
    step();
    step();
    chk("S6_stalled_valid", tb_valid, 1);
    chk("S6_stalled_idx", beat_idx, 0);
    cmp_en = 1'b0;
    reset = 1'b0;
    step();
    check_reset_outputs("S6rst");
    reset = 1'b1;
    run_align("S6again", 4, 4, 8'h1B, 8'h1B, 1, -1, -1, 0, 1'b0, 1'b1, 4, 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
